// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared types and default word format for the FIFO scheduler
package fifo_sched_pkg;

  // Default fixed-point format, shared with the fifo instance it drives
  localparam int DEFAULT_IL = 4;
  localparam int DEFAULT_FL = 16;

  // Which kind of access was granted in the previous cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 any
);

  int unsigned scan_idx;

  // Scan ptr, ptr+1, ... with wrap; the first requester seen wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!any && req[scan_idx]) begin
        any             = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = IDX_WIDTH'(scan_idx);
      end
    end
  end

endmodule

// File: rtl/fifo_sched.sv
// rtl/fifo_sched.sv - arbitrates writers and consumer reads onto one shared fifo
module fifo_sched
  import fifo_sched_pkg::*;
#(
  parameter int IL              = DEFAULT_IL,
  parameter int FL              = DEFAULT_FL,
  parameter int IN_BUS_WIDTH    = IL + FL,
  parameter int NUM_REQ         = 4,
  parameter int MAX_BURST       = 4,
  parameter int REQ_IDX_WIDTH   = $clog2(NUM_REQ),
  parameter int BURST_CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*IN_BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            rd_req,
  output logic                            rd_grant,
  output logic                            out_valid,
  output logic                            fifo_wr_en,
  output logic [IN_BUS_WIDTH-1:0]         fifo_data_in,
  output logic                            fifo_rd_en,
  input  logic                            fifo_empty,
  input  logic                            fifo_full
);

  localparam logic [BURST_CNT_WIDTH-1:0] BURST_MAX = BURST_CNT_WIDTH'(MAX_BURST);
  localparam logic [REQ_IDX_WIDTH-1:0]   LAST_IDX  = REQ_IDX_WIDTH'(NUM_REQ - 1);

  sched_state_t               state;
  logic [BURST_CNT_WIDTH-1:0] burst_cnt;
  logic [REQ_IDX_WIDTH-1:0]   rr_ptr;

  logic                     wr_pend;
  logic                     rd_pend;
  logic                     wr_sel;
  logic                     rd_sel;
  logic [NUM_REQ-1:0]       arb_grant;
  logic [REQ_IDX_WIDTH-1:0] arb_idx;
  logic                     arb_any;
  logic [IN_BUS_WIDTH-1:0]  wr_word;
  logic [REQ_IDX_WIDTH-1:0] next_ptr;

  // Full/empty flags are already exact, so they gate pending work directly
  assign wr_pend = (|req_valid) && !fifo_full;
  assign rd_pend = rd_req && !fifo_empty;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (REQ_IDX_WIDTH)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Pick at most one access type; reads win from idle, bursts yield after MAX_BURST
  always_comb begin
    wr_sel = 1'b0;
    rd_sel = 1'b0;
    if (!reset) begin
      if (wr_pend && rd_pend) begin
        case (state)
          S_WR:    if (burst_cnt < BURST_MAX) wr_sel = 1'b1; else rd_sel = 1'b1;
          S_RD:    if (burst_cnt < BURST_MAX) rd_sel = 1'b1; else wr_sel = 1'b1;
          default: rd_sel = 1'b1;
        endcase
      end else if (wr_pend) begin
        wr_sel = 1'b1;
      end else if (rd_pend) begin
        rd_sel = 1'b1;
      end
    end
  end

  // Route the winning writer's word onto the fifo input
  always_comb begin
    wr_word = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) wr_word = req_data[k*IN_BUS_WIDTH +: IN_BUS_WIDTH];
    end
  end

  assign next_ptr     = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
  assign req_ready    = (wr_sel && arb_any) ? arb_grant : '0;
  assign fifo_wr_en   = wr_sel;
  assign fifo_data_in = wr_sel ? wr_word : '0;
  assign fifo_rd_en   = rd_sel;
  assign rd_grant     = rd_sel;

  // Track last grant type, burst length and round-robin pointer; out_valid follows rd_grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_sel;
      if (wr_sel) begin
        rr_ptr <= next_ptr;
        state  <= S_WR;
        if (state == S_WR) begin
          if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= BURST_CNT_WIDTH'(1);
        end
      end else if (rd_sel) begin
        state <= S_RD;
        if (state == S_RD) begin
          if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= BURST_CNT_WIDTH'(1);
        end
      end else begin
        state     <= S_IDLE;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sched.sv
// tb/tb_fifo_sched.sv - directed self-checking bench for fifo_sched with a fifo model
module tb_fifo_sched;

  localparam int W     = 20;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*W-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          rd_req = 1'b0;
  logic          rd_grant;
  logic          out_valid;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_data_in;
  logic          fifo_rd_en;
  logic          fifo_empty;
  logic          fifo_full;

  int n_vec = 0;
  int n_err = 0;

  // fifo model: registered flags, read served in preference to write
  logic          fifo_clr = 1'b1;
  logic [W-1:0]  mem [0:DEPTH-1];
  logic [4:0]    wp, rp;
  logic [5:0]    occ;
  logic [W-1:0]  data_out;

  assign fifo_empty = (occ == 6'd0);
  assign fifo_full  = (occ == 6'd32);

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= '0; rp <= '0; occ <= '0; data_out <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      data_out <= mem[rp]; rp <= rp + 5'd1; occ <= occ - 6'd1;
    end else if (fifo_wr_en && !fifo_full) begin
      mem[wp] <= fifo_data_in; wp <= wp + 5'd1; occ <= occ + 6'd1;
    end
  end

  always #5 clk = ~clk;

  fifo_sched dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rd_req       (rd_req),
    .rd_grant     (rd_grant),
    .out_valid    (out_valid),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full)
  );

  task automatic test_reset();
    reset = 1'b1; fifo_clr = 1'b1; req_valid = 4'b1111; rd_req = 1'b1;
    req_data = {20'hD3333, 20'hC2222, 20'hB1111, 20'hA0000};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({req_ready, fifo_wr_en, fifo_rd_en, rd_grant, out_valid} !== 8'h00 || fifo_data_in !== 20'h0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got ready=%b wr=%b rd=%b grant=%b ov=%b data=%h, expected all zero",
                 c, req_ready, fifo_wr_en, fifo_rd_en, rd_grant, out_valid, fifo_data_in);
      end
    end
    @(negedge clk); reset = 1'b0; fifo_clr = 1'b0; #1;
    n_vec++;
    if ({req_ready, fifo_wr_en, fifo_rd_en, rd_grant} !== 7'b0001_100 || fifo_data_in !== 20'hA0000) begin
      n_err++;
      $display("FAIL post_reset_first_grant got ready=%b wr=%b rd=%b grant=%b data=%h, expected ready=0001 wr=1 rd=0 grant=0 data=a0000",
               req_ready, fifo_wr_en, fifo_rd_en, rd_grant, fifo_data_in);
    end
  endtask

  task automatic test_single_writer();
    @(negedge clk); reset = 1'b1; fifo_clr = 1'b1; req_valid = '0; rd_req = 1'b0;
    @(negedge clk); reset = 1'b0; fifo_clr = 1'b0;
    req_valid = 4'b0100; rd_req = 1'b1;
    req_data = {20'h0BEEF, 20'h12345, 20'h0CAFE, 20'h0F00D};
    #1;
    n_vec++;
    if ({req_ready, fifo_wr_en, fifo_rd_en} !== 6'b0100_10 || fifo_data_in !== 20'h12345) begin
      n_err++;
      $display("FAIL writer2_only got ready=%b wr=%b rd=%b data=%h, expected ready=0100 wr=1 rd=0 data=12345",
               req_ready, fifo_wr_en, fifo_rd_en, fifo_data_in);
    end
    @(negedge clk); req_valid = 4'b1111; #1;
    n_vec++;
    if ({req_ready, fifo_wr_en, fifo_rd_en} !== 6'b1000_10 || fifo_data_in !== 20'h0BEEF) begin
      n_err++;
      $display("FAIL ptr_after_writer2 got ready=%b wr=%b rd=%b data=%h, expected ready=1000 wr=1 rd=0 data=0beef",
               req_ready, fifo_wr_en, fifo_rd_en, fifo_data_in);
    end
  endtask

  task automatic test_fill_to_full();
    logic [W-1:0] words [0:3];
    words[0] = 20'hA0000; words[1] = 20'hB1111; words[2] = 20'hC2222; words[3] = 20'hD3333;
    @(negedge clk); reset = 1'b1; fifo_clr = 1'b1; req_valid = '0; rd_req = 1'b0;
    @(negedge clk); reset = 1'b0; fifo_clr = 1'b0;
    req_valid = 4'b1111; req_data = {words[3], words[2], words[1], words[0]};
    for (int c = 0; c < DEPTH; c++) begin
      #1;
      n_vec++;
      if (req_ready !== (4'b0001 << (c % 4)) || fifo_wr_en !== 1'b1 || fifo_data_in !== words[c % 4]) begin
        n_err++;
        $display("FAIL rr_fill cyc=%0d got ready=%b wr=%b data=%h, expected ready=%b wr=1 data=%h",
                 c, req_ready, fifo_wr_en, fifo_data_in, 4'b0001 << (c % 4), words[c % 4]);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0) begin
        n_err++;
        $display("FAIL full_hold cyc=%0d got ready=%b wr=%b, expected ready=0000 wr=0", c, req_ready, fifo_wr_en);
      end
      @(negedge clk);
    end
    rd_req = 1'b1; #1;
    n_vec++;
    if ({req_ready, fifo_wr_en, fifo_rd_en, rd_grant} !== 7'b0000_011) begin
      n_err++;
      $display("FAIL full_read got ready=%b wr=%b rd=%b grant=%b, expected ready=0000 wr=0 rd=1 grant=1",
               req_ready, fifo_wr_en, fifo_rd_en, rd_grant);
    end
    @(negedge clk); rd_req = 1'b0; #1;
    n_vec++;
    if (req_ready !== 4'b0001 || fifo_wr_en !== 1'b1 || out_valid !== 1'b1 || data_out !== 20'hA0000) begin
      n_err++;
      $display("FAIL resume_after_read got ready=%b wr=%b ov=%b data_out=%h, expected ready=0001 wr=1 ov=1 data_out=a0000",
               req_ready, fifo_wr_en, out_valid, data_out);
    end
  endtask

  task automatic test_read_latency();
    @(negedge clk); reset = 1'b1; fifo_clr = 1'b1; req_valid = '0; rd_req = 1'b0;
    @(negedge clk); reset = 1'b0; fifo_clr = 1'b0;
    req_valid = 4'b0010; req_data = {20'h0, 20'h0, 20'hABCDE, 20'h0};
    @(negedge clk); req_valid = '0; rd_req = 1'b1; #1;
    n_vec++;
    if (fifo_rd_en !== 1'b1 || rd_grant !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_issue got rd=%b grant=%b ov=%b, expected rd=1 grant=1 ov=0", fifo_rd_en, rd_grant, out_valid);
    end
    @(negedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b1 || data_out !== 20'hABCDE || fifo_empty !== 1'b1 || fifo_rd_en !== 1'b0 || rd_grant !== 1'b0) begin
      n_err++;
      $display("FAIL read_data got ov=%b data_out=%h empty=%b rd=%b grant=%b, expected ov=1 data_out=abcde empty=1 rd=0 grant=0",
               out_valid, data_out, fifo_empty, fifo_rd_en, rd_grant);
    end
    @(negedge clk); rd_req = 1'b0; #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_valid_drop got ov=%b, expected ov=0", out_valid);
    end
  endtask

  task automatic test_burst_alternation();
    logic [1:0] exp_en;
    @(negedge clk); reset = 1'b1; fifo_clr = 1'b1; req_valid = '0; rd_req = 1'b0;
    @(negedge clk); reset = 1'b0; fifo_clr = 1'b0;
    req_valid = 4'b0001; req_data = {20'h0, 20'h0, 20'h0, 20'h00555};
    repeat (16) @(negedge clk);
    rd_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      exp_en = (((c / 4) % 2) == 0) ? 2'b01 : 2'b10;
      n_vec++;
      if ({fifo_wr_en, fifo_rd_en} !== exp_en) begin
        n_err++;
        $display("FAIL burst_pattern cyc=%0d got wr=%b rd=%b, expected wr=%b rd=%b",
                 c, fifo_wr_en, fifo_rd_en, exp_en[1], exp_en[0]);
      end
      if (c == 0 || c == 8) begin
        n_vec++;
        if (occ !== 6'd16) begin
          n_err++;
          $display("FAIL burst_occupancy cyc=%0d got occ=%0d, expected 16", c, occ);
        end
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (occ !== 6'd16) begin
      n_err++;
      $display("FAIL burst_occupancy_end got occ=%0d, expected 16", occ);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk); reset = 1'b1; fifo_clr = 1'b1; req_valid = '0; rd_req = 1'b0;
    @(negedge clk); reset = 1'b0; fifo_clr = 1'b0;
    req_valid = 4'b1111; req_data = {20'hD3333, 20'hC2222, 20'hB1111, 20'hA0000};
    repeat (6) @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk); req_valid = 4'b0100; #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL midburst_setup got ready=%b, expected 0100", req_ready);
    end
    @(negedge clk); req_valid = 4'b1111; #1;
    n_vec++;
    if (req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL midburst_ptr3 got ready=%b, expected 1000", req_ready);
    end
    reset = 1'b1; #1;
    n_vec++;
    if ({req_ready, fifo_wr_en, fifo_rd_en} !== 6'b0) begin
      n_err++;
      $display("FAIL midburst_reset_gate got ready=%b wr=%b rd=%b, expected all zero", req_ready, fifo_wr_en, fifo_rd_en);
    end
    @(negedge clk); reset = 1'b0; rd_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if ({req_ready, fifo_wr_en, fifo_rd_en} !== 6'b0000_01) begin
        n_err++;
        $display("FAIL post_reset_read cyc=%0d got ready=%b wr=%b rd=%b, expected ready=0000 wr=0 rd=1",
                 c, req_ready, fifo_wr_en, fifo_rd_en);
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if ({req_ready, fifo_wr_en, fifo_rd_en} !== 6'b0001_10 || fifo_data_in !== 20'hA0000) begin
      n_err++;
      $display("FAIL post_reset_writer0 got ready=%b wr=%b rd=%b data=%h, expected ready=0001 wr=1 rd=0 data=a0000",
               req_ready, fifo_wr_en, fifo_rd_en, fifo_data_in);
    end
  endtask

  initial begin
    test_reset();
    test_single_writer();
    test_fill_to_full();
    test_read_latency();
    test_burst_alternation();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_sched.md
# fifo_sched

Sequencing controller for one shared fixed-point `fifo` instance. It round-robin arbitrates `NUM_REQ` writers onto the FIFO write port and schedules consumer read requests against those writes. It never asserts FIFO read and write in the same cycle. This matters because the FIFO serves a read in preference to a write and silently drops the write when both are asserted. The block sits between the accelerator's producer lanes and the single downstream consumer of the buffered words.

## Interface
Parameters:
- `IL`, 4, integer bits of fixed-point word
- `FL`, 16, fractional bits
- `IN_BUS_WIDTH`, `IL+FL`, word width
- `NUM_REQ`, 4, number of writers (≥2)
- `MAX_BURST`, 4, maximum consecutive same-type grants while the other type is pending (≥1)
- `REQ_IDX_WIDTH`, `$clog2(NUM_REQ)`, round-robin pointer width
- `BURST_CNT_WIDTH`, `$clog2(MAX_BURST+1)`, burst counter width

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: writer i has a word.
- `req_data` in `NUM_REQ*IN_BUS_WIDTH`: writer i word at slice `[i*IN_BUS_WIDTH +: IN_BUS_WIDTH]`.
- `req_ready` out `NUM_REQ`: one-hot or zero; writer i's word is consumed at this edge.
- `rd_req` in 1: consumer wants one word.
- `rd_grant` out 1: read issued this cycle.
- `out_valid` out 1: FIFO `data_out` holds the granted word this cycle.
- `fifo_wr_en` out 1: drives FIFO `wr_en`.
- `fifo_data_in` out `IN_BUS_WIDTH`: drives FIFO `data_in`.
- `fifo_rd_en` out 1: drives FIFO `rd_en`.
- `fifo_empty` in 1: FIFO `empty`.
- `fifo_full` in 1: FIFO `full`.

## Operation
- `wr_pend = |req_valid && !fifo_full`; `rd_pend = rd_req && !fifo_empty`.
- State `S_IDLE`, `S_WR`, `S_RD`, plus `burst_cnt` and `rr_ptr` registers.
- **Grant selection (combinational):**
  - Neither pending: no grant.
  - Only one pending: grant it.
  - Both pending:
    - From `S_IDLE`: grant read.
    - From `S_WR`: grant write if `burst_cnt < MAX_BURST`, else read.
    - From `S_RD`: grant read if `burst_cnt < MAX_BURST`, else write.
- **Write grant:** the selected writer is the first index with `req_valid` set, scanning from `rr_ptr` upward with wrap. On that grant:
  - `req_ready[i]=1`, `fifo_wr_en=1`, `fifo_data_in=req_data[i]`.
  - Next `rr_ptr = (i+1) mod NUM_REQ`.
- **Read grant:** `fifo_rd_en=1`, `rd_grant=1`.
- **Update on grant:**
  - If the grant type matches the current state, `burst_cnt` increments and saturates at `MAX_BURST`.
  - Otherwise `burst_cnt<=1`.
  - State becomes `S_WR` or `S_RD`.
- **Update on no grant:** state `S_IDLE`, `burst_cnt<=0`; `rr_ptr` unchanged.
- `rr_ptr` changes only on write grants.
- `fifo_data_in` is 0 when there is no write grant.
- `fifo_wr_en && fifo_rd_en` is never 1.

## Timing
- `req_ready`, `fifo_wr_en`, `fifo_rd_en`, `rd_grant` and `fifo_data_in` are combinational from registered state, `req_valid`, `rd_req` and the FIFO flags.
- The FIFO flags are registered and already reflect every op through the previous edge, so full/empty gating is exact with no lookahead.
- **Write latency:** word accepted at the edge ending the grant cycle.
- **Read latency:** `fifo_rd_en` in cycle t, then `out_valid=1` in cycle t+1, aligned with FIFO `data_out`.
- `out_valid` is the registered `rd_grant`. The consumer must sample `data_out` in that cycle; no backpressure on the output.
- **Reset values:**
  - State `S_IDLE`, `burst_cnt=0`, `rr_ptr=0`, `out_valid=0`.
  - While `reset` is high, all combinational outputs are forced to 0.
- **Reset mid-operation:** a pending burst is abandoned. The first cycle after reset behaves as from `S_IDLE` with `rr_ptr=0`.
- **Full FIFO:** writers are held (`req_ready=0`). The first read frees a slot; the FIFO clears `full` at that edge and writes resume the next cycle.
- **Empty FIFO:** `rd_req` is ignored, with no `rd_grant`. `rd_req` is level, not queued.

## Structure
- Package `fifo_sched_pkg` holds:
  - the state enum `sched_state_t` (`S_IDLE`, `S_WR`, `S_RD`);
  - default `IL`/`FL` localparams, shared with `fifo`.
- Sub-module `rr_arbiter`:
  - Inputs: `req[NUM_REQ]`, `ptr`.
  - Outputs: one-hot `grant`, `grant_idx`, `any`.
  - Purely combinational; reused by other lane arbiters.
- `fifo_sched` owns the state register, burst counter, pointer update and data mux.

## Test plan
1. Reset held 3 cycles with every writer valid and `rd_req=1` → all outputs 0. First post-reset cycle with empty FIFO grants writer 0.
2. Only writer 2 valid with `0x12345`, FIFO empty → same cycle: `req_ready=4'b0100`, `fifo_wr_en=1`, `fifo_data_in=0x12345`, `fifo_rd_en=0`.
3. All 4 writers valid continuously, no reads, `FIFO_DEPTH=32` → grants 0,1,2,3,0,… until `fifo_full=1`. Then `req_ready=0` every cycle. A single read resumes writes at the writer after the last granted index.
4. FIFO holding 1 word, `rd_req=1` → cycle t: `fifo_rd_en=1`; t+1: `out_valid=1` with the word on `data_out`, `fifo_empty=1`. t+1: no `fifo_rd_en`. t+2: `out_valid=0`.
5. FIFO half full, writer 0 and `rd_req` held continuously, `MAX_BURST=4` → enables R,R,R,R,W,W,W,W,R,…. Never both enables in one cycle; occupancy returns to its start value every 8 cycles.
6. Reset asserted during cycle 2 of a write burst with `rr_ptr=3` → after release: `burst_cnt=0`, `rr_ptr=0`, and with all writers valid plus `rd_req`, the first grant is a read, then writer 0 follows the read burst.
